alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control/datapath stage directly upstream of the combinational ALU.
- Accepts 20-bit instruction words over a valid/ready handshake and owns an 8 x 20-bit register file.
- Drives ALU opcode and operands, samples the ALU result and flags, and writes back.
- Sequences each instruction through IDLE -> EXEC -> WB (-> WB2 for SWAP) and holds the architectural C/Z/N flags.

Parameters:
- WIDTH, 20, data word width (register, operand and result width).
- NREGS, 8, register file depth. Addresses are 3 bits and are fixed at 3 bits.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  upstream has an instruction.
- instr_ready  out  1  sequencer can accept an instruction (high only in IDLE).
- instr  in  20  {opcode[19:6], rd[5:3], rs[2:0]}.
- alu_op  out  14  opcode to ALU.
- alu_a  out  20  operand A = R[rd] latched at accept.
- alu_b  out  20  operand B = R[rs] latched at accept.
- alu_cin  out  1  carry/borrow in; equals flag_c.
- alu_result  in  20  ALU result (combinational from alu_op/alu_a/alu_b).
- alu_cout  in  1  ALU carry/borrow out.
- alu_z  in  1  ALU zero/equal flag.
- alu_n  in  1  ALU negative/ordering flag.
- ext_we  in  1  external register write enable (load path).
- ext_waddr  in  3  external write address.
- ext_wdata  in  20  external write data.
- dbg_addr  in  3  debug read address.
- dbg_data  out  20  combinational R[dbg_addr].
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.
- flag_n  out  1  negative flag.
- done  out  1  one-cycle pulse in the final writeback/complete cycle.
- illegal  out  1  one-cycle pulse for an unrecognised opcode.

Behaviour:
- Reset (synchronous, rst high at edge):
  - state=IDLE; all registers R0..R7=0.
  - flag_c/z/n=0; alu_op/alu_a/alu_b=0; done=illegal=0.
  - Reset during any state aborts the instruction; no writeback, no flag update.
- Legal opcodes, 14-bit hex:
  - Result class: NOT 0A7, OR 0D1, AND 0BC, XOR 0E6, SHFTR 0FB, SHFTL 110, ROTR 125, ROTL 13A, INC 164, DEC 179, ADD 18E, ADDC 1A3, SUB 1B8, SUBC 1CD.
  - SWAP: 14F.
  - Compare class: EQ 1E2, GT 1F7, LT 20C, GET 221, LET 236.
  - Any other opcode is illegal.
- IDLE:
  - instr_ready=1.
  - On instr_valid at an edge: latch opcode/rd/rs; alu_op<=opcode; alu_a<=R[rd]; alu_b<=R[rs]. Reads use pre-edge register contents.
  - Legal opcode -> EXEC.
  - Illegal opcode -> ILL: illegal=1 for one cycle, no state change otherwise, then IDLE.
- EXEC (1 cycle, instr_ready=0):
  - At end of cycle, result_q<=alu_result.
  - ADDC/SUBC: flag_c<=alu_cout.
  - Compare class: flag_z<=alu_z, flag_n<=alu_n.
  - No other opcode touches flags. Next state is WB.
- WB:
  - Result class: R[rd]<=result_q at end of cycle; done=1; next IDLE.
  - Compare class: no register write; done=1; next IDLE.
  - SWAP: R[rd]<=alu_b; next WB2.
- WB2 (SWAP only): R[rs]<=alu_a; done=1; next IDLE.
- SWAP with rd==rs leaves the register unchanged; it still takes 4 cycles.
- Latency: accept edge E0; done is high in cycle E0+2 (E0+3 for SWAP).
  - Throughput is one instruction per 3 cycles (4 for SWAP, 2 for illegal).
  - Back-to-back instructions must observe the previous writeback.
- alu_cin is combinational from flag_c, so ADDC/SUBC use the flag value present during EXEC.
- External write:
  - Accepted in any state.
  - Same cycle, same address as an internal writeback: internal wins, external data is dropped.
  - Different addresses: both are written.
  - Operand latch in IDLE sees the pre-edge value even if ext_we targets the same register that cycle.
- done and illegal are never high in the same cycle.
- alu_op/alu_a/alu_b hold their values until the next accept.

Test Plan:
1. Reset; ext write R1=0x00005, R2=0x00003; instr={0x18E,1,2} (ADD) -> alu_a=5, alu_b=3, done in cycle E0+2, then dbg R1=0x00008, R2 unchanged.
2. ALU model returns alu_cout=1 on ADDC {0x1A3,1,2} -> flag_c=1 after EXEC; next ADDC drives alu_cin=1 during its EXEC; an ADD in between leaves flag_c=1.
3. R3=0xABCDE, R4=0x12345; SWAP {0x14F,3,4} -> R3=0x12345, R4=0xABCDE; exactly one done pulse at E0+3; instr_ready low for 3 cycles.
4. EQ {0x1E2,1,1} with alu_z=1, alu_n=0 -> flag_z=1, flag_n=0; all registers unchanged; done at E0+2.
5. instr opcode 0x000 -> illegal=1 for one cycle, no done, flags and registers unchanged, instr_ready high again 2 cycles after accept.
6. Two cases:
   - rst asserted during EXEC of ADD to R1 -> R1=0 and flags 0 after reset, no done.
   - Without reset, ext_we to R1=0x77777 during WB of ADD to R1 -> R1=ADD result.

Source files
------------

// File: rtl/alu_sequencer.sv
// Control stage in front of a combinational ALU. It accepts instructions over valid/ready,
// owns an 8 x WIDTH register file, and keeps the architectural C/Z/N flags.
module alu_sequencer #(
  parameter int WIDTH = 20,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [19:0]      instr,
  output logic [13:0]      alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             ext_we,
  input  logic [2:0]       ext_waddr,
  input  logic [WIDTH-1:0] ext_wdata,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             done,
  output logic             illegal
);

  localparam logic [13:0] OP_NOT   = 14'h0A7;
  localparam logic [13:0] OP_OR    = 14'h0D1;
  localparam logic [13:0] OP_AND   = 14'h0BC;
  localparam logic [13:0] OP_XOR   = 14'h0E6;
  localparam logic [13:0] OP_SHFTR = 14'h0FB;
  localparam logic [13:0] OP_SHFTL = 14'h110;
  localparam logic [13:0] OP_ROTR  = 14'h125;
  localparam logic [13:0] OP_ROTL  = 14'h13A;
  localparam logic [13:0] OP_SWAP  = 14'h14F;
  localparam logic [13:0] OP_INC   = 14'h164;
  localparam logic [13:0] OP_DEC   = 14'h179;
  localparam logic [13:0] OP_ADD   = 14'h18E;
  localparam logic [13:0] OP_ADDC  = 14'h1A3;
  localparam logic [13:0] OP_SUB   = 14'h1B8;
  localparam logic [13:0] OP_SUBC  = 14'h1CD;
  localparam logic [13:0] OP_EQ    = 14'h1E2;
  localparam logic [13:0] OP_GT    = 14'h1F7;
  localparam logic [13:0] OP_LT    = 14'h20C;
  localparam logic [13:0] OP_GET   = 14'h221;
  localparam logic [13:0] OP_LET   = 14'h236;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WB, S_WB2, S_ILL} state_t;
  typedef enum logic [1:0] {C_RESULT, C_SWAP, C_CMP, C_ILLEGAL} op_class_t;

  function automatic op_class_t classify(input logic [13:0] op);
    case (op)
      OP_NOT, OP_OR, OP_AND, OP_XOR, OP_SHFTR, OP_SHFTL, OP_ROTR, OP_ROTL,
      OP_INC, OP_DEC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: classify = C_RESULT;
      OP_SWAP:                                           classify = C_SWAP;
      OP_EQ, OP_GT, OP_LT, OP_GET, OP_LET:               classify = C_CMP;
      default:                                           classify = C_ILLEGAL;
    endcase
  endfunction

  state_t           state;
  op_class_t        cls_q;
  logic             carry_q;
  logic [2:0]       rd_q;
  logic [2:0]       rs_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic [13:0] in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  op_class_t   in_cls;

  assign in_op  = instr[19:6];
  assign in_rd  = instr[5:3];
  assign in_rs  = instr[2:0];
  assign in_cls = classify(in_op);

  assign instr_ready = (state == S_IDLE);
  assign alu_cin     = flag_c;
  assign dbg_data    = regs[dbg_addr];

  // NOTE: all state here uses non-blocking assignments, so the operand reads in IDLE
  // see pre-edge register contents even when a writeback or external write lands on
  // the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cls_q    <= C_RESULT;
      carry_q  <= 1'b0;
      rd_q     <= '0;
      rs_q     <= '0;
      result_q <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      // NOTE: the register file is reset word by word because software relies on
      // R0..R7 reading zero after reset; it is small enough to live in flops.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;

      // Internal writebacks below are assigned later, so they win on an address clash.
      if (ext_we) regs[ext_waddr] <= ext_wdata;

      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            alu_op  <= in_op;
            alu_a   <= regs[in_rd];
            alu_b   <= regs[in_rs];
            rd_q    <= in_rd;
            rs_q    <= in_rs;
            cls_q   <= in_cls;
            carry_q <= (in_op == OP_ADDC) || (in_op == OP_SUBC);
            if (in_cls == C_ILLEGAL) begin
              illegal <= 1'b1;
              state   <= S_ILL;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          result_q <= alu_result;
          if (carry_q) flag_c <= alu_cout;
          if (cls_q == C_CMP) begin
            flag_z <= alu_z;
            flag_n <= alu_n;
          end
          done  <= (cls_q != C_SWAP);
          state <= S_WB;
        end
        S_WB: begin
          case (cls_q)
            C_RESULT: begin
              regs[rd_q] <= result_q;
              state      <= S_IDLE;
            end
            C_SWAP: begin
              regs[rd_q] <= alu_b;
              done       <= 1'b1;
              state      <= S_WB2;
            end
            default: state <= S_IDLE;
          endcase
        end
        S_WB2: begin
          // With rd == rs this rewrites the original value, leaving the register unchanged.
          regs[rs_q] <= alu_a;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU drives the result inputs, and a reference
// model of the register file and flags predicts every visible outcome.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam logic [13:0] OP_NOT   = 14'h0A7;
  localparam logic [13:0] OP_OR    = 14'h0D1;
  localparam logic [13:0] OP_AND   = 14'h0BC;
  localparam logic [13:0] OP_XOR   = 14'h0E6;
  localparam logic [13:0] OP_SHFTR = 14'h0FB;
  localparam logic [13:0] OP_SHFTL = 14'h110;
  localparam logic [13:0] OP_ROTR  = 14'h125;
  localparam logic [13:0] OP_ROTL  = 14'h13A;
  localparam logic [13:0] OP_SWAP  = 14'h14F;
  localparam logic [13:0] OP_INC   = 14'h164;
  localparam logic [13:0] OP_DEC   = 14'h179;
  localparam logic [13:0] OP_ADD   = 14'h18E;
  localparam logic [13:0] OP_ADDC  = 14'h1A3;
  localparam logic [13:0] OP_SUB   = 14'h1B8;
  localparam logic [13:0] OP_SUBC  = 14'h1CD;
  localparam logic [13:0] OP_EQ    = 14'h1E2;
  localparam logic [13:0] OP_GT    = 14'h1F7;
  localparam logic [13:0] OP_LT    = 14'h20C;
  localparam logic [13:0] OP_GET   = 14'h221;
  localparam logic [13:0] OP_LET   = 14'h236;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [19:0] instr;
  logic [13:0] alu_op;
  logic [19:0] alu_a;
  logic [19:0] alu_b;
  logic        alu_cin;
  logic [19:0] alu_result;
  logic        alu_cout;
  logic        alu_z;
  logic        alu_n;
  logic        ext_we;
  logic [2:0]  ext_waddr;
  logic [19:0] ext_wdata;
  logic [2:0]  dbg_addr;
  logic [19:0] dbg_data;
  logic        flag_c;
  logic        flag_z;
  logic        flag_n;
  logic        done;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] m_regs [8];
  logic        m_fc, m_fz, m_fn;

  logic [13:0] legal_ops [20] = '{OP_NOT, OP_OR, OP_AND, OP_XOR, OP_SHFTR, OP_SHFTL,
                                  OP_ROTR, OP_ROTL, OP_SWAP, OP_INC, OP_DEC, OP_ADD,
                                  OP_ADDC, OP_SUB, OP_SUBC, OP_EQ, OP_GT, OP_LT,
                                  OP_GET, OP_LET};

  alu_sequencer #(.WIDTH(20), .NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_z(alu_z), .alu_n(alu_n),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .done(done), .illegal(illegal)
  );

  always #10 clk = ~clk;

  // Behavioural ALU: returns {cout, z, n, result}.
  function automatic logic [22:0] alu_fn(input logic [13:0] op, input logic [19:0] a,
                                         input logic [19:0] b, input logic cin);
    logic [20:0] w;
    logic        z, n, cmp;
    w = '0; n = 1'b0; cmp = 1'b0;
    case (op)
      OP_NOT:   w = {1'b0, ~a};
      OP_OR:    w = {1'b0, a | b};
      OP_AND:   w = {1'b0, a & b};
      OP_XOR:   w = {1'b0, a ^ b};
      OP_SHFTR: w = {1'b0, a >> 1};
      OP_SHFTL: w = {a, 1'b0};
      OP_ROTR:  w = {1'b0, a[0], a[19:1]};
      OP_ROTL:  w = {1'b0, a[18:0], a[19]};
      OP_INC:   w = {1'b0, a} + 21'd1;
      OP_DEC:   w = {1'b0, a} - 21'd1;
      OP_ADD:   w = {1'b0, a} + {1'b0, b};
      OP_ADDC:  w = {1'b0, a} + {1'b0, b} + 21'(cin);
      OP_SUB:   w = {1'b0, a} - {1'b0, b};
      OP_SUBC:  w = {1'b0, a} - {1'b0, b} - 21'(cin);
      OP_EQ:    cmp = 1'b1;
      OP_GT:    begin cmp = 1'b1; n = (a >  b); end
      OP_LT:    begin cmp = 1'b1; n = (a <  b); end
      OP_GET:   begin cmp = 1'b1; n = (a >= b); end
      OP_LET:   begin cmp = 1'b1; n = (a <= b); end
      default:  ;
    endcase
    z = cmp ? (a == b) : (w[19:0] == 20'd0);
    if (!cmp) n = w[19];
    return {w[20], z, n, w[19:0]};
  endfunction

  assign {alu_cout, alu_z, alu_n, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

  // 0 = writes rd, 1 = swap, 2 = compare, 3 = illegal
  function automatic int kind_of(input logic [13:0] op);
    if (op inside {OP_NOT, OP_OR, OP_AND, OP_XOR, OP_SHFTR, OP_SHFTL, OP_ROTR, OP_ROTL,
                   OP_INC, OP_DEC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC}) return 0;
    if (op == OP_SWAP) return 1;
    if (op inside {OP_EQ, OP_GT, OP_LT, OP_GET, OP_LET}) return 2;
    return 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; uses 8 ns of the 10 ns low phase.
  task automatic check_state();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check($sformatf("R%0d", i), 32'(dbg_data), 32'(m_regs[i]));
    end
    check("flag_c", 32'(flag_c), 32'(m_fc));
    check("flag_z", 32'(flag_z), 32'(m_fz));
    check("flag_n", 32'(flag_n), 32'(m_fn));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_fc = 1'b0; m_fz = 1'b0; m_fn = 1'b0;
  endtask

  task automatic ext_write(input logic [2:0] addr, input logic [19:0] data);
    ext_we = 1'b1; ext_waddr = addr; ext_wdata = data;
    @(negedge clk);
    ext_we = 1'b0;
    m_regs[addr] = data;
  endtask

  // Issues one instruction while in IDLE; optionally fires an external write during
  // cycle ext_cyc after the accept edge (0 = the accept cycle itself, -1 = none).
  task automatic run_instr(input logic [13:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input int ext_cyc, input logic [2:0] ext_a, input logic [19:0] ext_d);
    logic [19:0] a, b;
    logic [22:0] r;
    int kind, lat, done_at, ill_at, n_done;
    kind = kind_of(op);
    lat  = (kind == 3) ? 1 : (kind == 1) ? 3 : 2;
    a = m_regs[rd];
    b = m_regs[rs];
    check("ready_idle", 32'(instr_ready), 32'd1);
    instr = {op, rd, rs};
    instr_valid = 1'b1;
    if (ext_cyc == 0) begin ext_we = 1'b1; ext_waddr = ext_a; ext_wdata = ext_d; end
    done_at = -1; ill_at = -1; n_done = 0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      ext_we = 1'b0;
      if (k == ext_cyc && k <= lat) begin
        ext_we = 1'b1; ext_waddr = ext_a; ext_wdata = ext_d;
      end
      if (k == 1) begin
        check("alu_op", 32'(alu_op), 32'(op));
        check("alu_a", 32'(alu_a), 32'(a));
        check("alu_b", 32'(alu_b), 32'(b));
        if (op == OP_ADDC || op == OP_SUBC) check("alu_cin", 32'(alu_cin), 32'(m_fc));
      end
      check($sformatf("ready_k%0d", k), 32'(instr_ready), 32'(k > lat));
      if (done) begin n_done++; if (done_at < 0) done_at = k; end
      if (illegal && ill_at < 0) ill_at = k;
      check("done_illegal_excl", 32'(done & illegal), 32'd0);
    end
    check("done_count", 32'(n_done), (kind == 3) ? 32'd0 : 32'd1);
    check("done_cycle", 32'(done_at), (kind == 3) ? 32'hFFFF_FFFF : 32'(lat));
    check("illegal_cycle", 32'(ill_at), (kind == 3) ? 32'd1 : 32'hFFFF_FFFF);

    // Reference: external write first, then the instruction's own writeback wins.
    if (ext_cyc >= 0 && ext_cyc <= lat) m_regs[ext_a] = ext_d;
    r = alu_fn(op, a, b, m_fc);
    case (kind)
      0: begin
        m_regs[rd] = r[19:0];
        if (op == OP_ADDC || op == OP_SUBC) m_fc = r[22];
      end
      1: begin
        m_regs[rd] = b;
        m_regs[rs] = a;
      end
      2: begin
        m_fz = r[21];
        m_fn = r[20];
      end
      default: ;
    endcase
    check_state();
  endtask

  initial begin
    logic [13:0] op;
    int ec;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0; dbg_addr = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check_state();

    // Basic ADD
    ext_write(3'd1, 20'h00005);
    ext_write(3'd2, 20'h00003);
    run_instr(OP_ADD, 3'd1, 3'd2, -1, 3'd0, 20'd0);
    check("add_r1", 32'(m_regs[1]), 32'h8);

    // Carry chain: ADDC sets C, ADD keeps it, next ADDC consumes it
    ext_write(3'd1, 20'hFFFFF);
    ext_write(3'd2, 20'h00001);
    run_instr(OP_ADDC, 3'd1, 3'd2, -1, 3'd0, 20'd0);
    run_instr(OP_ADD,  3'd3, 3'd2, -1, 3'd0, 20'd0);
    check("flag_c_held", 32'(flag_c), 32'd1);
    run_instr(OP_ADDC, 3'd1, 3'd2, -1, 3'd0, 20'd0);

    // SWAP, including the rd == rs corner
    ext_write(3'd3, 20'hABCDE);
    ext_write(3'd4, 20'h12345);
    run_instr(OP_SWAP, 3'd3, 3'd4, -1, 3'd0, 20'd0);
    run_instr(OP_SWAP, 3'd5, 3'd5, -1, 3'd0, 20'd0);

    // Compare and illegal
    run_instr(OP_EQ, 3'd1, 3'd1, -1, 3'd0, 20'd0);
    run_instr(14'h0000, 3'd1, 3'd2, -1, 3'd0, 20'd0);
    run_instr(14'h3FFF, 3'd6, 3'd7, -1, 3'd0, 20'd0);

    // External write collisions: same address in WB, operand latch at accept, different address
    run_instr(OP_ADD, 3'd1, 3'd2, 2, 3'd1, 20'h77777);
    run_instr(OP_INC, 3'd2, 3'd2, 0, 3'd2, 20'h55555);
    run_instr(OP_SUB, 3'd6, 3'd3, 2, 3'd7, 20'h13579);
    run_instr(OP_SWAP, 3'd0, 3'd1, 2, 3'd1, 20'h2468A);

    // Reset during EXEC aborts the instruction
    ext_write(3'd1, 20'h00042);
    instr = {OP_ADD, 3'd1, 3'd2};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    check("abort_done_exec", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("abort_done_after", 32'(done), 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    check_state();
    @(negedge clk);
    check("abort_no_late_done", 32'(done), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 8; i++) ext_write(3'(i), 20'($urandom));
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 14'($urandom);
        if (kind_of(op) != 3) op = 14'h0000;
      end else begin
        op = legal_ops[$urandom_range(0, 19)];
      end
      ec = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_instr(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                ec, 3'($urandom_range(0, 7)), 20'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
